// File: rtl/regfile_dump_ctrl.sv
// Register-file dump initiator: walks every register through a spare read port
// and streams a framed byte sequence (header, index+data per register, checksum).
module regfile_dump_ctrl #(
    parameter int          NUM_REGS = 32,
    parameter int          ADDR_W   = 5,
    parameter int          DATA_W   = 32,
    parameter logic [7:0]  HDR_BYTE = 8'hA5
) (
    input  logic              clk_i,
    input  logic              rst_i,
    input  logic              start_i,
    output logic              busy_o,
    output logic              done_o,
    output logic [ADDR_W-1:0] rf_addr_o,
    input  logic [DATA_W-1:0] rf_data_i,
    output logic [7:0]        tx_data_o,
    output logic              tx_valid_o,
    input  logic              tx_ready_i
);

    localparam int BYTES = DATA_W / 8;
    localparam int CNT_W = $clog2(BYTES + 1);

    typedef enum logic [2:0] {IDLE, HDR, LOAD, IDX, DATA, SUM, DONE} state_t;

    state_t            state;
    logic [DATA_W-1:0] shift_reg;
    logic [DATA_W-1:0] shifted;
    logic [CNT_W-1:0]  byte_cnt;
    logic [7:0]        checksum;
    logic [7:0]        sum_next;
    logic              accept;
    logic              last_byte;
    logic              last_reg;

    assign accept    = tx_valid_o & tx_ready_i;
    assign shifted   = shift_reg >> 8;
    assign sum_next  = checksum + tx_data_o;
    assign last_byte = (byte_cnt == CNT_W'(BYTES - 1));
    assign last_reg  = (rf_addr_o == ADDR_W'(NUM_REGS - 1));

    // tx_data_o is preloaded one state ahead so the byte on the wire is always
    // a register; nothing advances while the sink stalls a valid byte.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state      <= IDLE;
            busy_o     <= 1'b0;
            done_o     <= 1'b0;
            rf_addr_o  <= '0;
            tx_valid_o <= 1'b0;
            tx_data_o  <= '0;
            checksum   <= '0;
            shift_reg  <= '0;
            byte_cnt   <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (start_i) begin
                        state      <= HDR;
                        busy_o     <= 1'b1;
                        rf_addr_o  <= '0;
                        checksum   <= '0;
                        tx_valid_o <= 1'b1;
                        tx_data_o  <= HDR_BYTE;
                    end
                end
                HDR: begin
                    if (accept) begin
                        state      <= LOAD;
                        tx_valid_o <= 1'b0;
                    end
                end
                LOAD: begin
                    shift_reg  <= rf_data_i;
                    tx_data_o  <= 8'(rf_addr_o);
                    tx_valid_o <= 1'b1;
                    state      <= IDX;
                end
                IDX: begin
                    if (accept) begin
                        checksum  <= sum_next;
                        byte_cnt  <= '0;
                        tx_data_o <= shift_reg[7:0];
                        state     <= DATA;
                    end
                end
                DATA: begin
                    if (accept) begin
                        checksum  <= sum_next;
                        shift_reg <= shifted;
                        byte_cnt  <= byte_cnt + 1'b1;
                        if (!last_byte) begin
                            tx_data_o <= shifted[7:0];
                        end else if (last_reg) begin
                            tx_data_o <= sum_next;
                            state     <= SUM;
                        end else begin
                            rf_addr_o  <= rf_addr_o + 1'b1;
                            tx_valid_o <= 1'b0;
                            state      <= LOAD;
                        end
                    end
                end
                SUM: begin
                    if (accept) begin
                        tx_valid_o <= 1'b0;
                        busy_o     <= 1'b0;
                        done_o     <= 1'b1;
                        state      <= DONE;
                    end
                end
                DONE: begin
                    done_o <= 1'b0;
                    state  <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_regfile_dump_ctrl.sv
// Randomized bench for regfile_dump_ctrl: accepted bytes are collected and
// compared with frames built directly from the register contents.
module tb_regfile_dump_ctrl;

    localparam int NR    = 32;
    localparam int NB    = 4;
    localparam int FLEN  = 1 + NR * (1 + NB) + 1;

    logic        clk = 1'b0;
    logic        rst;
    logic        start;
    logic        busy;
    logic        done;
    logic [4:0]  rf_addr;
    logic [31:0] rf_data;
    logic [7:0]  tx_data;
    logic        tx_valid;
    logic        tx_ready = 1'b1;

    logic [31:0] regs [NR];
    logic [7:0]  got_q[$];
    logic [7:0]  exp_q[$];
    int          n_tests = 0;
    int          n_fail  = 0;
    int          n_done  = 0;
    int          len_at_done = 0;
    bit          rdy_mode = 1'b0;
    bit          prev_stall = 1'b0;
    logic [7:0]  prev_data = '0;

    assign rf_data = regs[rf_addr];

    regfile_dump_ctrl dut (
        .clk_i      (clk),
        .rst_i      (rst),
        .start_i    (start),
        .busy_o     (busy),
        .done_o     (done),
        .rf_addr_o  (rf_addr),
        .rf_data_i  (rf_data),
        .tx_data_o  (tx_data),
        .tx_valid_o (tx_valid),
        .tx_ready_i (tx_ready)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, wanted %0h", tag, got, exp);
        end
    endtask

    always @(negedge clk) tx_ready = rdy_mode ? ($urandom_range(2) == 0) : 1'b1;

    // Sink-side monitor: collects transfers, counts done pulses, checks stall stability.
    always @(posedge clk) begin
        if (prev_stall && !rst)
            chk("stall_hold", {55'd0, tx_valid, tx_data}, {55'd0, 1'b1, prev_data});
        if (!rst && tx_valid && tx_ready) got_q.push_back(tx_data);
        if (!rst && done) begin
            n_done++;
            len_at_done = got_q.size();
        end
        prev_stall = !rst && tx_valid && !tx_ready;
        prev_data  = tx_data;
    end

    task automatic build_exp();
        logic [7:0] s;
        s = '0;
        exp_q.delete();
        exp_q.push_back(8'hA5);
        for (int r = 0; r < NR; r++) begin
            exp_q.push_back(8'(r));
            s += 8'(r);
            for (int b = 0; b < NB; b++) begin
                exp_q.push_back(regs[r][8*b +: 8]);
                s += regs[r][8*b +: 8];
            end
        end
        exp_q.push_back(s);
    endtask

    task automatic cmp_frame(input string tag, input int off);
        for (int i = 0; i < FLEN; i++) begin
            if (off + i >= got_q.size()) begin
                chk({tag, "_short"}, 64'(got_q.size()), 64'(off + FLEN));
                break;
            end
            chk(tag, 64'(got_q[off+i]), 64'(exp_q[i]));
            if (got_q[off+i] !== exp_q[i]) break;
        end
    endtask

    task automatic start_pulse();
        @(negedge clk) start = 1'b1;
        @(negedge clk) start = 1'b0;
    endtask

    task automatic wait_done(input int target);
        int k;
        k = 0;
        while (n_done < target && k < 3000) begin
            @(negedge clk);
            k++;
        end
        chk("done_timeout", 64'(n_done >= target), 64'd1);
    endtask

    task automatic rand_regs();
        for (int r = 0; r < NR; r++) regs[r] = $urandom;
    endtask

    initial begin
        int d0;
        int busy_bad;
        int done_bad;
        int k;
        logic [7:0] r1 [5];
        logic [31:0] old5;

        rst = 1'b1;
        start = 1'b0;
        for (int r = 0; r < NR; r++) regs[r] = '0;
        repeat (3) @(negedge clk);
        chk("rst_busy", 64'(busy), 64'd0);
        chk("rst_done", 64'(done), 64'd0);
        chk("rst_addr", 64'(rf_addr), 64'd0);
        chk("rst_valid", 64'(tx_valid), 64'd0);
        chk("rst_data", 64'(tx_data), 64'd0);
        rst = 1'b0;
        repeat (2) @(negedge clk);

        // All-zero registers with exact cycle timing
        build_exp();
        got_q.delete();
        d0 = n_done;
        busy_bad = 0;
        done_bad = 0;
        start = 1'b1;
        @(posedge clk);
        for (int c = 1; c <= 196; c++) begin
            @(negedge clk);
            if (c == 1) start = 1'b0;
            if (busy !== (c <= 194)) busy_bad++;
            if (done !== (c == 195)) done_bad++;
        end
        chk("t1_busy_window", 64'(busy_bad), 64'd0);
        chk("t1_done_cycle", 64'(done_bad), 64'd0);
        chk("t1_done_count", 64'(n_done), 64'(d0 + 1));
        chk("t1_len", 64'(got_q.size()), 64'(FLEN));
        cmp_frame("t1_frame", 0);
        chk("t1_hdr", 64'(got_q[0]), 64'hA5);
        chk("t1_idx1", 64'(got_q[6]), 64'h01);
        chk("t1_cksum", 64'(got_q[FLEN-1]), 64'hF0);

        // Single non-zero register, known bytes
        regs[1] = 32'h12345678;
        build_exp();
        got_q.delete();
        d0 = n_done;
        start_pulse();
        wait_done(d0 + 1);
        r1 = '{8'h01, 8'h78, 8'h56, 8'h34, 8'h12};
        for (int i = 0; i < 5; i++) chk("t2_reg1", 64'(got_q[6+i]), 64'(r1[i]));
        chk("t2_cksum", 64'(got_q[FLEN-1]), 64'h04);
        cmp_frame("t2_frame", 0);

        // Random contents, throttled sink
        rdy_mode = 1'b1;
        for (int f = 0; f < 3; f++) begin
            rand_regs();
            build_exp();
            got_q.delete();
            d0 = n_done;
            start_pulse();
            wait_done(d0 + 1);
            chk("t3_len", 64'(got_q.size()), 64'(FLEN));
            cmp_frame("t3_frame", 0);
        end

        // start held high (with glitches) across two frames
        rand_regs();
        build_exp();
        got_q.delete();
        d0 = n_done;
        @(negedge clk) start = 1'b1;
        @(posedge clk);
        k = 0;
        while (n_done == d0 && k < 3000) begin
            @(negedge clk);
            start = ($urandom_range(9) != 0);
            k++;
        end
        start = 1'b1;
        chk("t4_first_done", 64'(n_done), 64'(d0 + 1));
        chk("t4_len_at_done", 64'(len_at_done), 64'(FLEN));
        k = 0;
        while (!busy && k < 20) begin
            @(negedge clk);
            k++;
        end
        start = 1'b0;
        chk("t4_restart", 64'(busy), 64'd1);
        wait_done(d0 + 2);
        chk("t4_len2", 64'(got_q.size()), 64'(2 * FLEN));
        cmp_frame("t4_frame1", 0);
        cmp_frame("t4_frame2", FLEN);
        repeat (3) @(negedge clk);
        chk("t4_no_third", 64'(n_done), 64'(d0 + 2));

        // Reset during register 10 data bytes
        rand_regs();
        build_exp();
        got_q.delete();
        start_pulse();
        k = 0;
        while (got_q.size() < 54 && k < 3000) begin
            @(negedge clk);
            k++;
        end
        chk("t5_reach_reg10", 64'(rf_addr), 64'd10);
        d0 = n_done;
        #2 rst = 1'b1;
        #1;
        chk("t5_busy", 64'(busy), 64'd0);
        chk("t5_done", 64'(done), 64'd0);
        chk("t5_addr", 64'(rf_addr), 64'd0);
        chk("t5_valid", 64'(tx_valid), 64'd0);
        chk("t5_data", 64'(tx_data), 64'd0);
        repeat (2) @(negedge clk);
        rst = 1'b0;
        chk("t5_no_done", 64'(n_done), 64'(d0));
        got_q.delete();
        start_pulse();
        wait_done(d0 + 1);
        chk("t5_len", 64'(got_q.size()), 64'(FLEN));
        cmp_frame("t5_frame", 0);

        // Write to x5 while the dump is at register 3
        rdy_mode = 1'b0;
        rand_regs();
        if (regs[5] == 32'hDEADBEEF) regs[5] = 32'h0;
        old5 = regs[5];
        regs[5] = 32'hDEADBEEF;
        build_exp();
        regs[5] = old5;
        got_q.delete();
        d0 = n_done;
        start_pulse();
        k = 0;
        while (rf_addr != 5'd3 && k < 200) begin
            @(negedge clk);
            k++;
        end
        chk("t6_at_reg3", 64'(rf_addr), 64'd3);
        regs[5] = 32'hDEADBEEF;
        wait_done(d0 + 1);
        chk("t6_x5", 64'({got_q[30], got_q[29], got_q[28], got_q[27]}), 64'hDEADBEEF);
        cmp_frame("t6_frame", 0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/regfile_dump_ctrl.md
Name: regfile_dump_ctrl

Overview:
- Read-side initiator for the processor register file: on a start request it walks all register addresses through a read port and streams the contents out as a byte stream.
- The stream uses a valid/ready handshake and feeds the debug UART transmitter.
- Replaces file-based register dumps, which are simulation-only, with a synthesizable on-chip path.
- Sits beside the register file and uses a spare read port (rf_addr_o / rf_data_i).

Parameters:
NUM_REGS, 32, number of registers dumped (addresses 0..NUM_REGS-1)
ADDR_W, 5, register address width
DATA_W, 32, register data width; must be a multiple of 8
HDR_BYTE, 8'hA5, frame header byte

Ports:
clk_i  input  1  clock, rising edge
rst_i  input  1  asynchronous, active-high reset
start_i  input  1  request a dump; sampled only in IDLE
busy_o  output  1  high from the cycle after start is accepted until the checksum byte is accepted
done_o  output  1  one-cycle pulse after frame completion
rf_addr_o  output  ADDR_W  register read address, registered
rf_data_i  input  DATA_W  combinational read data for rf_addr_o
tx_data_o  output  8  stream byte
tx_valid_o  output  1  stream byte valid
tx_ready_i  input  1  sink ready; a byte transfers on a rising edge with tx_valid_o & tx_ready_i

Behaviour:
- One clock domain (clk_i). Reset is asynchronous and active-high on rst_i.
- Reset values: busy_o=0, done_o=0, rf_addr_o=0, tx_valid_o=0, tx_data_o=0, checksum=0, state=IDLE.
- Frame format: HDR_BYTE, then for each register r=0..NUM_REGS-1: index byte r, then the DATA_W/8 data bytes, least-significant byte first. Last comes the checksum byte.
- Frame length: 1 + NUM_REGS*(1+DATA_W/8) + 1 bytes, i.e. 162 with defaults.
- Checksum = sum mod 256 of every byte after the header (index and data bytes). The header is excluded.
- FSM states: IDLE, HDR, LOAD, IDX, DATA, SUM, DONE.
- IDLE: start_i=1 -> HDR. Also rf_addr_o<=0 and checksum<=0.
- HDR: tx_valid_o=1, tx_data_o=HDR_BYTE. On accept -> LOAD.
- LOAD: exactly one cycle with tx_valid_o=0. Captures rf_data_i (for the current rf_addr_o) into a shift register, then -> IDX.
- IDX: tx_data_o = rf_addr_o zero-extended to 8 bits. On accept -> DATA with byte counter=0.
- DATA: tx_data_o = shift register [7:0]. On accept: shift right by 8 and increment the counter.
  - After the last byte, if rf_addr_o==NUM_REGS-1 -> SUM.
  - Otherwise rf_addr_o++ and -> LOAD.
- SUM: tx_data_o = checksum. On accept -> DONE.
- DONE: done_o=1 and busy_o=0 for one cycle, then -> IDLE.
- While tx_valid_o=1 and tx_ready_i=0: tx_data_o and tx_valid_o hold stable. No state, address or checksum change.
- Checksum accumulates each index or data byte in the cycle it is accepted.
- Latency, tx_ready_i tied high: start sampled in cycle 0; header in cycle 1; each register takes 6 cycles (LOAD + 5 bytes); checksum in cycle 194; done_o in cycle 195.
- start_i is ignored in every state except IDLE, including DONE.
- Register-file writes during a dump are allowed. Each word is the value present during its LOAD cycle, so the snapshot is not atomic across registers.
- Address 0 is read like any other register; the dumper does not special-case it.
- Reset mid-frame aborts immediately. tx_valid_o drops without a handshake and the sink must resynchronise on HDR_BYTE. No done_o is produced for the aborted frame.

Test Plan:
1. All registers 0, tx_ready_i=1, pulse start_i -> 162 bytes: A5; then 00 00 00 00 00, 01 00 00 00 00, ... 1F 00 00 00 00; checksum F0. done_o at cycle 195; busy_o high cycles 1..194.
2. x1=0x12345678, all others 0 -> register-1 bytes are 01 78 56 34 12; checksum 04.
3. tx_ready_i toggling 1-of-3 cycles, random register contents -> the byte sequence matches a reference model exactly. No byte is duplicated or dropped, and tx_data_o stays stable while valid && !ready.
4. start_i held high for the whole dump and re-pulsed mid-frame -> exactly one frame per IDLE entry. The second frame's header appears only after done_o.
5. rst_i asserted while sending register 10's data bytes -> all outputs reach their reset values asynchronously. A following start_i yields a full, correct frame starting with A5.
6. Write x5=0xDEADBEEF while rf_addr_o==3 -> the dump reports x5=DEADBEEF, since it is captured at x5's LOAD cycle.
